// File: rtl/sort_order_sched_pkg.sv
// Shared types and constants for the sort order scheduler and its arbiter.
package sort_sched_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    RESP       = 3'd4
  } sched_state_e;

  typedef logic [1:0] resp_code_t;

  localparam resp_code_t CODE_OK      = 2'd0;
  localparam resp_code_t CODE_RANGE   = 2'd1;
  localparam resp_code_t CODE_TIMEOUT = 2'd2;

  // Requester index width; a single requester still gets one id bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_order_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above rr_ptr, wrapping.
module rr_arbiter
  import sort_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_idx,
  output logic               gnt_any
);

  logic [IDW-1:0] idx_s;

  // Scan from the pointer upward and keep only the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx_s   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx_s = IDW'((int'(rr_ptr) + off) % NUM_REQ);
      if (!gnt_any && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
        gnt_any    = 1'b1;
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/sort_order_sched.sv
// Round-robin front end for one sort engine: grants one order at a time,
// range-checks it, issues it and reports completion with a status code.
module sort_order_sched
  import sort_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int MEM_DEPTH     = 65536,
  parameter int START_TIMEOUT = 16,
  localparam int IDW = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_start,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  output logic [IDW-1:0]                resp_id,
  output logic [1:0]                    resp_code,
  output logic                          order_valid,
  output logic [ADDR_WIDTH-1:0]         order_start,
  output logic [DATA_WIDTH-1:0]         order_len,
  input  logic                          order_busy,
  output logic                          sched_busy
);

  localparam int SUMW = ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + 1;
  localparam int CW   = $clog2(START_TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [SUMW-1:0] DEPTH_W  = SUMW'(MEM_DEPTH);
  localparam logic [IDW-1:0]  ID_LAST  = IDW'(NUM_REQ - 1);

  sched_state_e          state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [IDW-1:0]        id_q, id_d;
  resp_code_t            code_q, code_d;
  logic                  order_valid_q, order_valid_d;
  logic                  resp_valid_q, resp_valid_d;

  logic [NUM_REQ-1:0]    gnt_s;
  logic [IDW-1:0]        gnt_idx_s;
  logic                  gnt_any_s;
  logic                  grant_en_s;
  logic [ADDR_WIDTH-1:0] sel_start_s;
  logic [DATA_WIDTH-1:0] sel_len_s;
  logic [SUMW-1:0]       sum_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .gnt_any (gnt_any_s)
  );

  assign grant_en_s = (state_q == IDLE) && !order_busy && gnt_any_s;
  assign sum_s      = SUMW'(sel_start_s) + SUMW'(sel_len_s);

  // Pick the winner's start/len slices out of the packed request buses.
  always_comb begin
    sel_start_s = '0;
    sel_len_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        sel_start_s = req_start[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len_s   = req_len[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_start_s = sel_start_s;
      end
    end
  end

  // Grant strobe; masked during reset so no request is consumed while aborted.
  always_comb begin
    if (grant_en_s && !rst) begin
      req_ready = gnt_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    len_d    = len_q;
    id_d     = id_q;
    code_d   = code_q;
    case (state_q)
      IDLE: begin
        if (grant_en_s) begin
          start_d = sel_start_s;
          len_d   = sel_len_s;
          id_d    = gnt_idx_s;
          if (sum_s > DEPTH_W) begin
            code_d  = CODE_RANGE;
            state_d = RESP;
          end else if (sel_len_s == '0) begin
            code_d  = CODE_OK;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (order_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = CODE_TIMEOUT;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!order_busy) begin
          code_d  = CODE_OK;
          state_d = RESP;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      RESP: begin
        if (id_q == ID_LAST) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = id_q + IDW'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    order_valid_d = (state_d == ISSUE);
    resp_valid_d  = (state_d == RESP);
  end

  // State and output registers; reset aborts any order in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      start_q       <= '0;
      len_q         <= '0;
      id_q          <= '0;
      code_q        <= CODE_OK;
      order_valid_q <= 1'b0;
      resp_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      start_q       <= start_d;
      len_q         <= len_d;
      id_q          <= id_d;
      code_q        <= code_d;
      order_valid_q <= order_valid_d;
      resp_valid_q  <= resp_valid_d;
    end
  end

  assign order_valid = order_valid_q;
  assign order_start = start_q;
  assign order_len   = len_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = id_q;
  assign resp_code   = code_q;
  assign sched_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sort_order_sched.sv
// Randomised and directed bench for sort_order_sched with a transaction-level
// timing model: each grant schedules its issue, engine busy window and response.
module tb_sort_order_sched;

  localparam int N = 4, AW = 16, DW = 16, MEM = 65536, ST = 16, MAXC = 8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_start;
  logic [N*DW-1:0] req_len;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic [1:0]      resp_id;
  logic [1:0]      resp_code;
  logic            order_valid;
  logic [AW-1:0]   order_start;
  logic [DW-1:0]   order_len;
  logic            order_busy;
  logic            sched_busy;

  sort_order_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                     .MEM_DEPTH(MEM), .START_TIMEOUT(ST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_start(req_start),
    .req_len(req_len), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_code(resp_code), .order_valid(order_valid),
    .order_start(order_start), .order_len(order_len), .order_busy(order_busy),
    .sched_busy(sched_busy)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // requester side and per-order engine behaviour (k = cycles after issue until busy, 0 = never)
  bit          pend [N];
  logic [15:0] p_start [N];
  logic [15:0] p_len [N];
  int          e_k [N];
  int          e_l [N];
  bit          ext_busy = 1'b0;

  // scheduled expectations indexed by absolute cycle
  bit          exp_ov_a [MAXC];
  bit          exp_rv_a [MAXC];
  bit          exp_sb_a [MAXC];
  bit          busy_a [MAXC];
  logic [15:0] exp_os_a [MAXC];
  logic [15:0] exp_ol_a [MAXC];
  logic [1:0]  exp_rid_a [MAXC];
  logic [1:0]  exp_rc_a [MAXC];
  logic [N-1:0] exp_rr;
  int m_ptr = 0, m_free_at = 0;

  // observations of the DUT used only for literal timing checks
  int grant_log[$];
  int grant_cyc[$];
  int last_ov = 0, last_rv = 0, ov_count = 0;
  logic [1:0]  last_rc, last_rid;
  logic [15:0] cap_os, cap_ol;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      exp_ov_a[c] = 1'b0; exp_rv_a[c] = 1'b0; exp_sb_a[c] = 1'b0; busy_a[c] = 1'b0;
      exp_os_a[c] = '0; exp_ol_a[c] = '0; exp_rid_a[c] = '0; exp_rc_a[c] = '0;
    end
  endtask

  // Decide whether this cycle grants and, if so, schedule the whole order's timeline.
  task automatic model_step();
    int w, g, v, r, s, l;
    logic [1:0] code;
    w = -1;
    exp_rr = '0;
    if (cyc >= m_free_at && !order_busy) begin
      for (int off = 0; off < N; off++)
        if (w < 0 && pend[(m_ptr + off) % N]) w = (m_ptr + off) % N;
    end
    if (w >= 0) begin
      exp_rr[w] = 1'b1;
      g = cyc;
      s = int'(p_start[w]);
      l = int'(p_len[w]);
      if (s + l > MEM) begin
        r = g + 1; code = 2'd1;
      end else if (l == 0) begin
        r = g + 1; code = 2'd0;
      end else begin
        v = g + 1;
        exp_ov_a[v] = 1'b1; exp_os_a[v] = p_start[w]; exp_ol_a[v] = p_len[w];
        if (e_k[w] == 0) begin
          r = v + ST + 1; code = 2'd2;
        end else begin
          for (int j = 0; j < e_l[w]; j++) busy_a[v + e_k[w] + j] = 1'b1;
          r = v + e_k[w] + e_l[w] + 1; code = 2'd0;
        end
      end
      exp_rv_a[r] = 1'b1; exp_rid_a[r] = w[1:0]; exp_rc_a[r] = code;
      for (int c = g + 1; c <= r; c++) exp_sb_a[c] = 1'b1;
      m_free_at = r + 1;
      m_ptr = (w + 1) % N;
      pend[w] = 1'b0;
    end
  endtask

  task automatic drive_and_model();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_start[i*AW +: AW] = p_start[i];
      req_len[i*DW +: DW] = p_len[i];
    end
    order_busy = busy_a[cyc] | ext_busy;
    model_step();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive_and_model();
  endtask

  task automatic set_req(input int i, input int s, input int l, input int k, input int bl);
    p_start[i] = 16'(s); p_len[i] = 16'(l); e_k[i] = k; e_l[i] = bl; pend[i] = 1'b1;
  endtask

  function automatic bit any_pend();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= pend[i];
    return a;
  endfunction

  task automatic wait_idle(input int bound);
    int b = 0;
    while (!(cyc >= m_free_at && !any_pend()) && b < bound) begin
      step();
      b++;
    end
    n_checks++;
    if (!(cyc >= m_free_at && !any_pend())) begin
      n_fail++;
      $display("FAIL wait_idle at cycle %0d: still busy after %0d cycles", cyc, bound);
    end
    step();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_order_valid"}, 32'(order_valid), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_sched_busy"}, 32'(sched_busy), 32'd0);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_resp_code"}, 32'(resp_code), 32'd0);
    chk({tag, "_order_start"}, 32'(order_start), 32'd0);
    chk({tag, "_order_len"}, 32'(order_len), 32'd0);
  endtask

  // Per-cycle compare against the scheduled model, plus observation logging.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      chk("order_valid", 32'(order_valid), 32'(exp_ov_a[cyc]));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv_a[cyc]));
      chk("sched_busy", 32'(sched_busy), 32'(exp_sb_a[cyc]));
      if (exp_ov_a[cyc]) begin
        chk("order_start", 32'(order_start), 32'(exp_os_a[cyc]));
        chk("order_len", 32'(order_len), 32'(exp_ol_a[cyc]));
      end
      if (exp_rv_a[cyc]) begin
        chk("resp_id", 32'(resp_id), 32'(exp_rid_a[cyc]));
        chk("resp_code", 32'(resp_code), 32'(exp_rc_a[cyc]));
      end
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin grant_log.push_back(i); grant_cyc.push_back(cyc); end
      if (order_valid) begin last_ov = cyc; ov_count++; cap_os = order_start; cap_ol = order_len; end
      if (resp_valid) begin last_rv = cyc; last_rc = resp_code; last_rid = resp_id; end
    end
  end

  initial begin
    int n, n2, ovc, rel, b;
    int exp_rr_order [5];
    rst = 1'b1; req_valid = '0; req_start = '0; req_len = '0; order_busy = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; p_start[i] = '0; p_len[i] = '0; e_k[i] = 1; e_l[i] = 1; end
    clear_from(0);
    #3;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; cyc = 0; m_free_at = 0; chk_en = 1'b1;
    drive_and_model();

    // round robin: all four at once, then 0 and 3 reissued once 2 is granted
    for (int i = 0; i < N; i++) set_req(i, i * 256, 4, 2, 3);
    b = 0;
    while (grant_log.size() < 3 && b < 300) begin step(); b++; end
    set_req(0, 16'h1000, 4, 1, 2);
    set_req(3, 16'h2000, 4, 1, 2);
    wait_idle(300);
    exp_rr_order = '{0, 1, 2, 3, 0};
    chk("rr_count", 32'(grant_log.size()), 32'd5);
    for (int j = 0; j < 5; j++)
      if (j < grant_log.size()) chk("rr_order", 32'(grant_log[j]), 32'(exp_rr_order[j]));

    // single order: busy rises 1 cycle after issue for 10 cycles
    set_req(0, 0, 7, 1, 10);
    wait_idle(100);
    chk("single_issue_lat", 32'(last_ov - grant_cyc[grant_cyc.size()-1]), 32'd1);
    chk("single_resp_lat", 32'(last_rv - last_ov), 32'd12);
    chk("single_start", 32'(cap_os), 32'd0);
    chk("single_len", 32'(cap_ol), 32'd7);
    chk("single_id", 32'(last_rid), 32'd0);
    chk("single_code", 32'(last_rc), 32'd0);

    // range error, exact-fit boundary, zero length
    ovc = ov_count;
    set_req(2, 65530, 10, 1, 1);
    wait_idle(50);
    chk("range_lat", 32'(last_rv - grant_cyc[grant_cyc.size()-1]), 32'd1);
    chk("range_code", 32'(last_rc), 32'd1);
    chk("range_id", 32'(last_rid), 32'd2);
    chk("range_no_issue", 32'(ov_count), 32'(ovc));
    set_req(1, 65530, 6, 1, 2);
    wait_idle(50);
    chk("fit_code", 32'(last_rc), 32'd0);
    chk("fit_issued", 32'(ov_count), 32'(ovc + 1));
    ovc = ov_count;
    set_req(1, 5, 0, 1, 1);
    wait_idle(50);
    chk("zero_lat", 32'(last_rv - grant_cyc[grant_cyc.size()-1]), 32'd1);
    chk("zero_code", 32'(last_rc), 32'd0);
    chk("zero_no_issue", 32'(ov_count), 32'(ovc));

    // timeout: engine never responds
    set_req(3, 100, 3, 0, 0);
    wait_idle(100);
    chk("timeout_lat", 32'(last_rv - last_ov), 32'(ST + 1));
    chk("timeout_code", 32'(last_rc), 32'd2);
    chk("timeout_id", 32'(last_rid), 32'd3);

    // busy blocking in IDLE
    ext_busy = 1'b1;
    n = grant_log.size();
    set_req(0, 10, 2, 1, 1);
    repeat (6) step();
    chk("blocked_no_grant", 32'(grant_log.size()), 32'(n));
    ext_busy = 1'b0;
    rel = cyc + 1;
    wait_idle(50);
    if (grant_cyc.size() > n) chk("unblock_grant_cyc", 32'(grant_cyc[n]), 32'(rel));
    else chk("unblock_granted", 32'(grant_log.size()), 32'(n + 1));

    // reset in WAIT_DONE with requests 1 and 3 pending; pointer must restart at 0
    n = grant_log.size();
    set_req(2, 200, 5, 1, 30);
    b = 0;
    while (grant_log.size() <= n && b < 50) begin step(); b++; end
    repeat (8) step();
    chk("pre_reset_busy", 32'(sched_busy), 32'd1);
    set_req(3, 300, 4, 1, 2);
    set_req(1, 400, 4, 1, 2);
    step();
    #2;
    rst = 1'b1;
    chk_en = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    clear_from(cyc);
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc += 2;
    rst = 1'b0;
    m_free_at = cyc;
    n2 = grant_log.size();
    chk_en = 1'b1;
    drive_and_model();
    wait_idle(100);
    chk("post_reset_grants", 32'(grant_log.size()), 32'(n2 + 2));
    if (grant_log.size() >= n2 + 2) begin
      chk("post_reset_first", 32'(grant_log[n2]), 32'd1);
      chk("post_reset_second", 32'(grant_log[n2 + 1]), 32'd3);
    end

    // randomised traffic
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 9) == 0) begin
          int s, l, r;
          s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(65500, 65535)) : int'($urandom_range(0, 65535));
          r = int'($urandom_range(0, 7));
          l = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(0, 64)) : int'($urandom_range(1, 20));
          set_req(i, s, l, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, ST)),
                  int'($urandom_range(1, 6)));
        end else if (pend[i] && $urandom_range(0, 63) == 0) begin
          pend[i] = 1'b0;
        end
      end
      if (ext_busy) ext_busy = ($urandom_range(0, 3) != 0);
      else if (cyc + 1 >= m_free_at && $urandom_range(0, 15) == 0) ext_busy = 1'b1;
      step();
    end
    ext_busy = 1'b0;
    wait_idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_order_sched.md
Name: sort_order_sched

Overview:
- Round-robin scheduler that shares one sort_system engine between NUM_REQ requesters.
- Accepts one sort order at a time and range-checks it against memory depth.
- Issues the order to the engine using its order_valid/order_busy protocol, then reports completion and a status code.
- Sits directly in front of sort_system; it is the only driver of order_valid, order_start and order_len.

Parameters:
- NUM_REQ, 4, number of requesters (1 or more).
- DATA_WIDTH, 16, width of order_len.
- ADDR_WIDTH, 16, width of order_start.
- MEM_DEPTH, 65536, words in the engine RAM; used for the range check.
- START_TIMEOUT, 16, cycles allowed after issue for order_busy to rise (2 or more).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester order request
- req_start  in  NUM_REQ*ADDR_WIDTH  packed start addresses; requester i occupies slice i
- req_len  in  NUM_REQ*DATA_WIDTH  packed lengths; requester i occupies slice i
- req_ready  out  NUM_REQ  one-hot grant pulse; the request is consumed that cycle
- resp_valid  out  1  one-cycle completion pulse
- resp_id  out  IDW  requester index for resp_valid; IDW = max(1, clog2(NUM_REQ))
- resp_code  out  2  0 OK, 1 RANGE_ERR, 2 TIMEOUT
- order_valid  out  1  one-cycle issue pulse to the engine
- order_start  out  ADDR_WIDTH  start address to the engine
- order_len  out  DATA_WIDTH  length to the engine
- order_busy  in  1  engine busy
- sched_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: every output 0, state IDLE, rr_ptr 0, timeout counter 0.
- Reset mid-operation aborts immediately; order_valid and resp_valid drop asynchronously; no response is generated for the aborted order.
- Requester rule: hold req_valid and data stable until req_ready. Dropping req_valid before grant is legal and has no side effect.
- IDLE:
  - Grants only when some req_valid is high and order_busy is 0.
  - Winner is the first requester with req_valid high, searching from rr_ptr upward with wrap.
  - req_ready[winner] is high for exactly that cycle, decoded combinationally from state and grant.
  - Latches start, len and id.
  - Range check in ADDR_WIDTH+1 bits: if start+len > MEM_DEPTH, set code RANGE_ERR and go to RESP.
  - Else if len == 0, set code OK and go to RESP; the engine is not touched.
  - Else go to ISSUE.
- ISSUE: order_valid=1 for one cycle; clear the counter; go to WAIT_START.
- order_start and order_len hold the latched values in every state after grant. They are not required to be 0 outside ISSUE.
- WAIT_START:
  - order_busy=1: go to WAIT_DONE.
  - Else counter == START_TIMEOUT-1: set code TIMEOUT and go to RESP.
  - Else increment the counter.
- WAIT_DONE: when order_busy=0, set code OK and go to RESP. There is no timeout in this state.
- RESP: resp_valid=1 for one cycle with resp_id and resp_code; set rr_ptr = (id+1) mod NUM_REQ; go to IDLE.
- Latency:
  - Grant at cycle T; order_valid at T+1.
  - Response is 1 cycle after order_busy is first sampled low in WAIT_DONE.
  - len==0 or range error: response at T+1.
  - Re-grant is possible in the cycle after RESP.
- Simultaneous requests resolve in round-robin order with no starvation. A requester waits at most NUM_REQ-1 other orders.
- order_busy high while in IDLE (engine still busy from elsewhere) blocks granting; no req_ready is asserted.

Decomposition:
- Package sort_sched_pkg:
  - state enum: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP
  - resp code constants: CODE_OK=0, CODE_RANGE=1, CODE_TIMEOUT=2
  - 2-bit resp_code typedef
- Sub-module rr_arbiter: combinational, parameterised by NUM_REQ. Inputs req vector and rr_ptr; outputs one-hot grant and index. The scheduler owns the pointer update.

Test Plan:
- Single order (req 0, start 0, len 7; engine busy 1..10 cycles after order_valid; RAM {1,2,5,1,3,7,5}):
  - order_valid pulse with order_start=0 and order_len=7.
  - resp_valid with id 0, code 0 one cycle after busy falls.
  - RAM reads {1,1,2,3,5,5,7}.
- Round-robin (all 4 req_valid high at once, each len 4):
  - Grants in order 0,1,2,3.
  - Reissue requests 0 and 3 after req 1 completes: order continues 2,3,0.
- Range and zero length:
  - req 2 with start 65530, len 10: resp code 1 at T+1, no order_valid.
  - len 0: code 0 at T+1, no order_valid.
- Timeout (engine model never raises busy): resp code 2 exactly START_TIMEOUT+1 cycles after order_valid.
- Busy blocking: order_busy held high in IDLE with req_valid pending; no req_ready until busy drops, then grant on the next clock edge.
- Reset mid WAIT_DONE:
  - All outputs 0 asynchronously and state IDLE.
  - After release, a pending request is re-granted from rr_ptr 0.
